// File: rtl/vision_pipeline_sequencer.sv
// Frame sequencer for the vision chain: capture -> extract -> search -> optional
// ethernet query (timeout + retries) -> display, with frame/drop statistics.
module vision_pipeline_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int RETRIES = 2,
    parameter int FCW     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic           cam_go,
    input  logic           cam_done,
    output logic           ext_go,
    input  logic           ext_done,
    output logic           srch_go,
    input  logic           srch_done,
    input  logic           srch_need_q,
    output logic           eth_go,
    input  logic           eth_ack,
    output logic           disp_go,
    input  logic           disp_done,
    output logic           busy,
    output logic           err,
    input  logic           err_clr,
    output logic [FCW-1:0] frame_cnt,
    output logic [FCW-1:0] drop_cnt,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAP  = 3'd1,
        S_EXT  = 3'd2,
        S_SRCH = 3'd3,
        S_ETH  = 3'd4,
        S_DISP = 3'd5
    } state_t;

    localparam int            TW     = $clog2(TIMEOUT);
    // Timer counts down to zero; zero marks the last cycle an ack is accepted.
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
    localparam logic [2:0]    R_MAX  = 3'(RETRIES);

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     retry_q, retry_d;
    logic           cam_go_q, cam_go_d;
    logic           ext_go_q, ext_go_d;
    logic           srch_go_q, srch_go_d;
    logic           eth_go_q, eth_go_d;
    logic           disp_go_q, disp_go_d;
    logic           busy_q;
    logic           err_q, err_d;
    logic [FCW-1:0] frame_q, frame_d;
    logic [FCW-1:0] drop_q, drop_d;
    logic           expire;

    assign expire = (timer_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            retry_q   <= '0;
            cam_go_q  <= 1'b0;
            ext_go_q  <= 1'b0;
            srch_go_q <= 1'b0;
            eth_go_q  <= 1'b0;
            disp_go_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            frame_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            cam_go_q  <= cam_go_d;
            ext_go_q  <= ext_go_d;
            srch_go_q <= srch_go_d;
            eth_go_q  <= eth_go_d;
            disp_go_q <= disp_go_d;
            busy_q    <= (state_d != S_IDLE);
            err_q     <= err_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (run)       state_d = S_CAP;
            S_CAP:  if (cam_done)  state_d = S_EXT;
            S_EXT:  if (ext_done)  state_d = S_SRCH;
            S_SRCH: if (srch_done) state_d = srch_need_q ? S_ETH : S_DISP;
            S_ETH: begin
                // An ack in the expiry cycle takes priority over retry/abandon.
                if (eth_ack)     state_d = S_DISP;
                else if (expire) state_d = (retry_q < R_MAX) ? S_ETH : S_IDLE;
            end
            S_DISP: if (disp_done) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cam_go_d  = 1'b0;
        ext_go_d  = 1'b0;
        srch_go_d = 1'b0;
        eth_go_d  = 1'b0;
        disp_go_d = 1'b0;
        timer_d   = timer_q;
        retry_d   = retry_q;
        frame_d   = frame_q;
        drop_d    = drop_q;
        err_d     = err_q & ~err_clr;
        unique case (state_q)
            S_IDLE: cam_go_d  = run;
            S_CAP:  ext_go_d  = cam_done;
            S_EXT:  srch_go_d = ext_done;
            S_SRCH: begin
                if (srch_done) begin
                    if (srch_need_q) begin
                        eth_go_d = 1'b1;
                        timer_d  = T_LOAD;
                        retry_d  = '0;
                    end else begin
                        disp_go_d = 1'b1;
                    end
                end
            end
            S_ETH: begin
                if (eth_ack) begin
                    disp_go_d = 1'b1;
                end else if (expire) begin
                    if (retry_q < R_MAX) begin
                        eth_go_d = 1'b1;
                        timer_d  = T_LOAD;
                        retry_d  = retry_q + 3'd1;
                    end else begin
                        // Abandon: setting err overrides a simultaneous err_clr.
                        err_d  = 1'b1;
                        drop_d = drop_q + FCW'(1);
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DISP: if (disp_done) frame_d = frame_q + FCW'(1);
            default: ;
        endcase
    end

    assign cam_go    = cam_go_q;
    assign ext_go    = ext_go_q;
    assign srch_go   = srch_go_q;
    assign eth_go    = eth_go_q;
    assign disp_go   = disp_go_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vision_pipeline_sequencer.sv
// Bench for vision_pipeline_sequencer: cycle vector table, async-reset sequence,
// and a responder-driven event scoreboard fed by a frame-level timing model.
module tb_vision_pipeline_sequencer;

    localparam int TO  = 8;
    localparam int RT  = 2;
    localparam int FCW = 16;
    localparam int NP  = 15;
    localparam int NV  = 35;

    localparam int EV_CAM = 1, EV_EXT = 2, EV_SRCH = 3, EV_ETH = 4;
    localparam int EV_DISP = 5, EV_FRAME = 6, EV_DROP = 7;

    typedef struct {
        logic [7:0]     in_v;   // run,cam_done,ext_done,srch_done,need,eth_ack,disp_done,err_clr
        logic [6:0]     out_v;  // cam,ext,srch,eth,disp,busy,err
        logic [FCW-1:0] fc;
    } vec_t;

    typedef struct {
        int dc;
        int de;
        int ds;
        int dd;
        bit need;
        int ack[RT+1];          // per attempt: ack delay after eth_go, 0 = never
    } plan_t;

    logic clk = 1'b0, rst = 1'b1, run = 1'b0;
    logic cam_done = 1'b0, ext_done = 1'b0, srch_done = 1'b0, srch_need_q = 1'b0;
    logic eth_ack = 1'b0, disp_done = 1'b0, err_clr = 1'b0;
    logic cam_go, ext_go, srch_go, eth_go, disp_go, busy, err;
    logic [FCW-1:0] frame_cnt, drop_cnt;
    logic [2:0] dbg_state;
    logic [4:0] gos;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vec_t        vt[NV];
    plan_t       plans[NP];
    logic [31:0] exp_q[$];
    bit          drop_cyc[int];
    int          cnt[5];
    int          fi, att, cur, n_frames, n_drops;

    assign gos = {cam_go, ext_go, srch_go, eth_go, disp_go};

    vision_pipeline_sequencer #(.TIMEOUT(TO), .RETRIES(RT), .FCW(FCW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .cam_go(cam_go), .cam_done(cam_done),
        .ext_go(ext_go), .ext_done(ext_done),
        .srch_go(srch_go), .srch_done(srch_done), .srch_need_q(srch_need_q),
        .eth_go(eth_go), .eth_ack(eth_ack),
        .disp_go(disp_go), .disp_done(disp_done),
        .busy(busy), .err(err), .err_clr(err_clr),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d, dbg_state %0d)",
                     nm, act, exp, cyc, dbg_state);
        end
    endtask

    function automatic logic [31:0] ev(input int k, input int c);
        return {4'(k), 28'(c)};
    endfunction

    // Driver tasks
    task automatic clear_pulses();
        cam_done = 1'b0; ext_done = 1'b0; srch_done = 1'b0; srch_need_q = 1'b0;
        eth_ack = 1'b0; disp_done = 1'b0;
    endtask

    task automatic drive_done(input int s, input bit need);
        case (s)
            0: cam_done = 1'b1;
            1: ext_done = 1'b1;
            2: begin srch_done = 1'b1; srch_need_q = need; end
            3: eth_ack = 1'b1;
            default: disp_done = 1'b1;
        endcase
    endtask

    task automatic wait_go(input int bitn, input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            clear_pulses();
            n++;
            seen = gos[bitn];
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        clear_pulses();
        run = 1'b0;
        err_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic build_table();
        for (int i = 0; i < NV; i++) begin
            vt[i].in_v  = (i <= 19) ? 8'h80 : 8'h00;
            vt[i].out_v = ((i >= 1 && i <= 16) || (i >= 18 && i <= 31)) ? 7'h02 : 7'h00;
            vt[i].fc    = (i >= 32) ? FCW'(2) : (i >= 17) ? FCW'(1) : FCW'(0);
        end
        // Frame 1: local search result, each done 3 cycles after its go.
        vt[2].in_v[5]  = 1'b1;   // stray ext_done while capturing
        vt[4].in_v[6]  = 1'b1;
        vt[8].in_v[5]  = 1'b1;
        vt[10].in_v[2] = 1'b1;   // stray eth_ack during search
        vt[11].in_v[3] = 1'b1;   // need without srch_done
        vt[12].in_v[4] = 1'b1;
        vt[16].in_v[1] = 1'b1;
        // Frame 2: run drops in EXT, query answered 5 cycles after eth_go.
        vt[19].in_v[6] = 1'b1;
        vt[21].in_v[5] = 1'b1;
        vt[23].in_v[4] = 1'b1;
        vt[23].in_v[3] = 1'b1;
        vt[26].in_v[1] = 1'b1;   // stray disp_done during query
        vt[29].in_v[2] = 1'b1;
        vt[31].in_v[1] = 1'b1;
        vt[1].out_v[6]  = 1'b1;
        vt[5].out_v[5]  = 1'b1;
        vt[9].out_v[4]  = 1'b1;
        vt[13].out_v[2] = 1'b1;
        vt[18].out_v[6] = 1'b1;
        vt[20].out_v[5] = 1'b1;
        vt[22].out_v[4] = 1'b1;
        vt[24].out_v[3] = 1'b1;
        vt[30].out_v[2] = 1'b1;
    endtask

    task automatic set_plan(input int p, input int dc, input int de, input int ds, input int dd,
                            input bit need, input int a0, input int a1, input int a2);
        plans[p].dc = dc; plans[p].de = de; plans[p].ds = ds; plans[p].dd = dd;
        plans[p].need = need;
        plans[p].ack[0] = a0; plans[p].ack[1] = a1; plans[p].ack[2] = a2;
    endtask

    // Frame-level timing model: each go follows the previous done by one cycle,
    // each query attempt owns a TO-cycle window, the next frame starts 2 cycles after display done.
    task automatic build_exp(input int t0, output int t_last);
        int t;
        t = t0;
        n_frames = 0;
        n_drops = 0;
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back(ev(EV_CAM, t));
            t += plans[p].dc + 1;
            exp_q.push_back(ev(EV_EXT, t));
            t += plans[p].de + 1;
            exp_q.push_back(ev(EV_SRCH, t));
            t += plans[p].ds + 1;
            if (!plans[p].need) begin
                exp_q.push_back(ev(EV_DISP, t));
                t += plans[p].dd + 1;
                exp_q.push_back(ev(EV_FRAME, t));
                t += 1;
                n_frames++;
            end else begin
                for (int k = 0; k <= RT; k++) begin
                    exp_q.push_back(ev(EV_ETH, t));
                    if (plans[p].ack[k] != 0) begin
                        t += plans[p].ack[k] + 1;
                        exp_q.push_back(ev(EV_DISP, t));
                        t += plans[p].dd + 1;
                        exp_q.push_back(ev(EV_FRAME, t));
                        t += 1;
                        n_frames++;
                        break;
                    end
                    t += TO;
                    if (k == RT) begin
                        exp_q.push_back(ev(EV_DROP, t));
                        drop_cyc[t] = 1'b1;
                        t += 1;
                        n_drops++;
                    end
                end
            end
        end
        t_last = t;
    endtask

    // Scoreboard
    task automatic observe(input int k);
        logic [31:0] o;
        o = ev(k, cyc);
        if (exp_q.size() == 0) chk("sb_unexpected_event", o, 32'h0);
        else chk("sb_event", o, exp_q.pop_front());
    endtask

    initial begin
        int t0, t_last, end_cyc, s;
        logic [FCW-1:0] prev_fc, prev_dc;
        bit exp_err, prev_clr, nn;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({gos, busy, err}), 32'h0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
        rst = 1'b0;

        // Table-driven cycle vectors
        build_table();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_outputs", i), 32'({gos, busy, err}), 32'(vt[i].out_v));
            chk($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(vt[i].fc));
            {run, cam_done, ext_done, srch_done, srch_need_q, eth_ack, disp_done, err_clr} = vt[i].in_v;
        end
        @(negedge clk);
        clear_pulses();
        run = 1'b0;
        chk("table_drop_cnt", 32'(drop_cnt), 32'h0);

        // Asynchronous reset while waiting on the query
        run = 1'b1;
        wait_go(4, "mid_rst_cam_go");
        run = 1'b0;
        cam_done = 1'b1;
        wait_go(3, "mid_rst_ext_go");
        ext_done = 1'b1;
        wait_go(2, "mid_rst_srch_go");
        srch_done = 1'b1;
        srch_need_q = 1'b1;
        wait_go(1, "mid_rst_eth_go");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({gos, busy, err}), 32'h0);
        chk("async_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("async_rst_drop_cnt", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        wait_go(4, "post_rst_cam_go");
        run = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        do_reset();

        // Directed plans first, then random frames
        set_plan(0, 2, 1, 3, 2, 1'b1, 0, 2, 0);        // retry then success
        set_plan(1, 1, 2, 1, 1, 1'b1, TO - 1, 0, 0);   // ack in the expiry cycle
        set_plan(2, 3, 1, 2, 1, 1'b1, 0, 0, 0);        // abandon after all retries
        for (int p = 3; p < NP; p++) begin
            set_plan(p, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, TO - 1) : 0,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, TO - 1) : 0,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, TO - 1) : 0);
        end

        @(negedge clk);
        run = 1'b1;
        t0 = cyc + 1;
        build_exp(t0, t_last);
        end_cyc = t_last + 20;
        for (int s2 = 0; s2 < 5; s2++) cnt[s2] = 0;
        fi = -1; att = 0; cur = -1;
        prev_fc = '0; prev_dc = '0;
        exp_err = 1'b0; prev_clr = 1'b0;

        while (cyc < end_cyc) begin
            @(negedge clk);
            if (cam_go)  observe(EV_CAM);
            if (ext_go)  observe(EV_EXT);
            if (srch_go) observe(EV_SRCH);
            if (eth_go)  observe(EV_ETH);
            if (disp_go) observe(EV_DISP);
            if (frame_cnt != prev_fc) begin
                observe(EV_FRAME);
                chk("frame_cnt_step", 32'(frame_cnt), 32'(prev_fc + FCW'(1)));
                prev_fc = frame_cnt;
            end
            if (drop_cnt != prev_dc) begin
                observe(EV_DROP);
                chk("drop_cnt_step", 32'(drop_cnt), 32'(prev_dc + FCW'(1)));
                prev_dc = drop_cnt;
            end
            if (drop_cyc.exists(cyc)) exp_err = 1'b1;
            else if (prev_clr) exp_err = 1'b0;
            chk("err_level", 32'(err), 32'(exp_err));

            clear_pulses();
            srch_need_q = 1'($urandom_range(0, 1));
            nn = (fi >= 0) ? plans[(fi >= 0) ? fi : 0].need : 1'b0;
            for (int s3 = 0; s3 < 5; s3++) begin
                if (cnt[s3] > 0) begin
                    cnt[s3]--;
                    if (cnt[s3] == 0) drive_done(s3, nn);
                end
            end
            if (cam_go) begin
                if (fi < NP - 1) fi++;
                cnt[0] = plans[fi].dc;
                cur = 0;
                if (fi == NP - 1) run = 1'b0;
            end
            if (fi >= 0) begin
                if (ext_go)  begin cnt[1] = plans[fi].de; cur = 1; end
                if (srch_go) begin cnt[2] = plans[fi].ds; att = 0; cur = 2; end
                if (eth_go) begin
                    cnt[3] = (att <= RT) ? plans[fi].ack[(att <= RT) ? att : 0] : 0;
                    att++;
                    cur = 3;
                end
                if (disp_go) begin cnt[4] = plans[fi].dd; cur = 4; end
            end
            if ($urandom_range(0, 7) == 0) begin
                s = $urandom_range(0, 4);
                if (s != cur && cnt[s] == 0) drive_done(s, 1'($urandom_range(0, 1)));
            end
            err_clr = drop_cyc.exists(cyc + 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
            prev_clr = err_clr;
        end
        clear_pulses();
        err_clr = 1'b0;
        chk("sb_leftover_events", 32'(exp_q.size()), 32'd0);
        chk("sb_frame_total", 32'(frame_cnt), 32'(FCW'(n_frames)));
        chk("sb_drop_total", 32'(drop_cnt), 32'(FCW'(n_drops)));
        chk("sb_idle_at_end", 32'(busy), 32'd0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
